// File: rtl/sensor_bridge_pkg.sv
// Shared types and constants for the sensor command bridge:
// FSM state encoding, command word field layout and result flag position.
package sensor_bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_POP       = 4'd1,
        ST_LOAD      = 4'd2,
        ST_REQ       = 4'd3,
        ST_WAIT_HI   = 4'd4,
        ST_WAIT_LO   = 4'd5,
        ST_PUSH_WAIT = 4'd6,
        ST_PUSH      = 4'd7,
        ST_GAP       = 4'd8
    } state_t;

    // Command word layout: [15:0] sample count, [23:16] idle gap between requests.
    localparam int CNT_LSB = 0;
    localparam int CNT_W   = 16;
    localparam int GAP_LSB = 16;
    localparam int GAP_W   = 8;

    // The error flag always occupies the top bit of a result word.
    function automatic int err_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Depth is 2**FIFO_AW; pointers carry one extra wrap bit so full and empty
// are distinguishable when the address bits match.
module sync_fifo #(
    parameter int DATA_W  = 32,
    parameter int FIFO_AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Writes while full and reads while empty are silently ignored.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= din;
        end
    end

    // Pointer advance and registered read data; dout holds when nothing is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                dout   <= mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_fifo_bridge.sv
// Host-to-sensor command bridge. Each host command word asks for `count`
// request/busy handshakes with the sensor core, separated by `gap` idle
// cycles; every captured sample is pushed to the output FIFO as
// {err, zero pad, core_data}.
// Optional feature: define SENSOR_TIMEOUT_EN to bound each busy wait to
// TIMEOUT_CY cycles; on expiry an error word (err=1, data=0) is pushed and
// the rest of that command is abandoned.
module sensor_fifo_bridge
    import sensor_bridge_pkg::*;
#(
    parameter int          DATA_W     = 32,
    // CORE_W must leave room for the error flag in the top bit.
    parameter int          CORE_W     = 31,
    parameter int          FIFO_AW    = 9,
    parameter int unsigned TIMEOUT_CY = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic [DATA_W-1:0] dout,
    input  logic              rd_en,
    output logic              empty,
    output logic              req,
    input  logic              busy,
    input  logic [CORE_W-1:0] core_data,
    output logic              active
);

    logic [1:0]        rst_pipe;
    logic              rst_int_n;
    logic [DATA_W-1:0] in_dout;
    logic              in_empty;
    logic              in_rd;
    logic              out_full;
    logic              out_wr;
    logic [DATA_W-1:0] result;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [GAP_W-1:0]  cmd_gap;
    logic              abort_now;
    logic              unused_cmd;

    // Pack a sample into a host result word.
    function automatic logic [DATA_W-1:0] make_word(input logic err, input logic [CORE_W-1:0] data);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CORE_W-1:0] = data;
        w[err_bit(DATA_W)] = err;
        return w;
    endfunction

    assign cmd_cnt    = in_dout[CNT_LSB +: CNT_W];
    assign cmd_gap    = in_dout[GAP_LSB +: GAP_W];
    // Bits above the gap field carry no meaning for the bridge.
    assign unused_cmd = ^in_dout;

    // Reset is asserted asynchronously but released in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_int_n),
        .wr_en (wr_en),
        .din   (din),
        .full  (full),
        .rd_en (in_rd),
        .dout  (in_dout),
        .empty (in_empty)
    );

    sync_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_int_n),
        .wr_en (out_wr),
        .din   (result),
        .full  (out_full),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty)
    );

`ifdef SENSOR_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CY > 1) ? $clog2(TIMEOUT_CY) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            abort;

    assign abort_now = abort;
`else
    logic unused_cfg;

    assign abort_now  = 1'b0;
    // Timeout length only matters when the timeout feature is built in.
    assign unused_cfg = (TIMEOUT_CY == 0);
`endif

    // Command sequencer: pops commands, runs the handshakes, pushes results.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= ST_IDLE;
            req     <= 1'b0;
            active  <= 1'b0;
            in_rd   <= 1'b0;
            out_wr  <= 1'b0;
            cnt     <= '0;
            gap     <= '0;
            gap_cnt <= '0;
            result  <= '0;
`ifdef SENSOR_TIMEOUT_EN
            to_cnt  <= '0;
            abort   <= 1'b0;
`endif
        end else begin
            in_rd  <= 1'b0;
            out_wr <= 1'b0;
            req    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!in_empty) begin
                        in_rd <= 1'b1;
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    cnt <= cmd_cnt;
                    gap <= cmd_gap;
                    if (cmd_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        active <= 1'b1;
                        req    <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
`ifdef SENSOR_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!busy) begin
                        result <= make_word(1'b0, core_data);
                        state  <= ST_PUSH_WAIT;
                    end
                end
                ST_PUSH_WAIT: begin
                    // Hold the captured sample until the host makes room.
                    if (!out_full) begin
                        out_wr <= 1'b1;
                        state  <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 16'd1 || abort_now) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
`ifdef SENSOR_TIMEOUT_EN
                        abort  <= 1'b0;
`endif
                    end else if (gap == '0) begin
                        req   <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        gap_cnt <= gap - 1'b1;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        req   <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
`ifdef SENSOR_TIMEOUT_EN
            // A stuck core overrides the normal wait transitions.
            if (state == ST_WAIT_HI || state == ST_WAIT_LO) begin
                if (to_cnt == TO_W'(TIMEOUT_CY - 1)) begin
                    result <= make_word(1'b1, '0);
                    abort  <= 1'b1;
                    state  <= ST_PUSH_WAIT;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule
